// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready handshake, flush and payload bundle for an elastic pipeline stage
interface pipe_stage_skid_if #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic stage register with 2-entry skid buffer, flush, and STAGE_PERF_EN stall/bubble counters
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_d;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_d, skid_ctrl, skid_ctrl_d;
  logic [DATA_W-1:0] main_data, main_data_d, skid_data, skid_data_d;
  logic in_fire, out_fire;
  assign bus.in_ready  = state != FULL;
  assign bus.out_valid = state != EMPTY;
  assign bus.out_ctrl  = bus.out_valid ? main_ctrl : '0;
  assign bus.out_data  = main_data;
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  always_comb begin
    state_d     = state;
    main_ctrl_d = main_ctrl;
    main_data_d = main_data;
    skid_ctrl_d = skid_ctrl;
    skid_data_d = skid_data;
    case (state)
      EMPTY: if (in_fire) begin
        state_d     = ONE;
        main_ctrl_d = bus.in_ctrl;
        main_data_d = bus.in_data;
      end
      ONE: if (in_fire && out_fire) begin
        main_ctrl_d = bus.in_ctrl;
        main_data_d = bus.in_data;
      end else if (in_fire) begin
        state_d     = FULL;
        skid_ctrl_d = bus.in_ctrl;
        skid_data_d = bus.in_data;
      end else if (out_fire) begin
        state_d = EMPTY;
      end
      FULL: if (out_fire) begin
        state_d     = ONE;
        main_ctrl_d = skid_ctrl;
        main_data_d = skid_data;
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) begin
      state_d     = EMPTY;
      main_ctrl_d = main_ctrl;
      main_data_d = main_data;
      skid_ctrl_d = skid_ctrl;
      skid_data_d = skid_data;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_d;
      main_ctrl <= main_ctrl_d;
      main_data <= main_data_d;
      skid_ctrl <= skid_ctrl_d;
      skid_data <= skid_data_d;
    end
  end
`ifdef STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (!bus.out_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid with directed and random traffic
module tb_pipe_stage_skid;
  localparam int DATA_W = 128;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int MAX_CNT = (1 << CNT_W) - 1;
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();
  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  beat_t sb[$];
  int checks = 0;
  int failures = 0;
  int stall_m = 0;
  int bubble_m = 0;
  logic [DATA_W-1:0] last_d = '0;
  logic exp_ov, exp_ir;
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      stall_m  = 0;
      bubble_m = 0;
      last_d   = '0;
    end else begin
      exp_ov = sb.size() > 0;
      exp_ir = sb.size() < 2;
      chk("in_ready", DATA_W'(bus.in_ready), DATA_W'(exp_ir));
      chk("out_valid", DATA_W'(bus.out_valid), DATA_W'(exp_ov));
      if (exp_ov) begin
        chk("out_data", bus.out_data, sb[0].d);
        chk("out_ctrl", DATA_W'(bus.out_ctrl), DATA_W'(sb[0].c));
        last_d = sb[0].d;
      end else begin
        chk("bubble_ctrl", DATA_W'(bus.out_ctrl), '0);
        chk("bubble_data_hold", bus.out_data, last_d);
      end
`ifdef STAGE_PERF_EN
      chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(stall_m));
      chk("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(bubble_m));
`else
      chk("stall_cnt_tied", DATA_W'(stall_cnt), '0);
      chk("bubble_cnt_tied", DATA_W'(bubble_cnt), '0);
`endif
      if (exp_ov && !bus.out_ready && stall_m < MAX_CNT) stall_m++;
      if (!exp_ov && bubble_m < MAX_CNT) bubble_m++;
      if (exp_ov && bus.out_ready) void'(sb.pop_front());
      if (bus.flush) sb.delete();
      else if (bus.in_valid && exp_ir) sb.push_back('{bus.in_ctrl, bus.in_data});
    end
  end
  task automatic drive(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) drive(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 8'h01, 'hA, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 'hB, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 'hD, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 'hD, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 8'h04, 'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 'h12, 1'b0, 1'b0);
    drive(1'b1, 8'h06, 'hC, 1'b0, 1'b1);
    repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 8'hFF, 'h77, 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 8'h21, 'h55, 1'b0, 1'b0);
    repeat (20) drive(1'b0, '0, '0, 1'b0, 1'b0);
    pulse_reset();
    repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) pulse_reset();
      drive(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom()),
            {$urandom(), $urandom(), $urandom(), $urandom()},
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
